// File: rtl/game_state_manager.sv
// Per-frame collision folding plus top-level game FSM that owns score, lives and level.
// Optional one-time bonus life per game is built when BONUS_LIFE_EN is defined.
module game_state_manager #(
  parameter int INIT_LIVES      = 3,
  parameter int MAX_LIVES       = 7,
  parameter int MAX_LEVEL       = 9,
  parameter int PRIZE_POINTS    = 10,
  parameter int GATE_POINTS     = 100,
  parameter int SCORE_MAX       = 9999,
  parameter int INVULN_FRAMES   = 60,
  parameter int LEVEL_UP_FRAMES = 30
`ifdef BONUS_LIFE_EN
  ,
  parameter int BONUS_THRESHOLD = 500
`endif
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        start_game,
  input  logic        prize_collision,
  input  logic        gate_collision,
  input  logic        step_spike_collision,
  input  logic        border_collision,
  output logic [13:0] score,
  output logic [2:0]  lives,
  output logic [3:0]  level,
  output logic        playing,
  output logic        invulnerable,
  output logic        game_over,
  output logic        life_lost_pulse,
  output logic        level_up_pulse
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_HIT,
    S_LEVEL_UP,
    S_GAME_OVER
  } state_t;

  localparam int CNT_MAX = (INVULN_FRAMES > LEVEL_UP_FRAMES) ? INVULN_FRAMES : LEVEL_UP_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0]  LIVES_INIT = 3'((INIT_LIVES > MAX_LIVES) ? MAX_LIVES : INIT_LIVES);
  localparam logic [14:0] SCORE_CAP  = 15'(SCORE_MAX);

  state_t             state_q, state_d;
  logic               prz_q, gat_q, haz_q;
  logic               prz_d, gat_d, haz_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [13:0]        score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic [3:0]         level_q, level_d;
  logic               life_lost_q, life_lost_d;
  logic               level_up_q, level_up_d;

  logic               haz_in;
  logic [14:0]        score_sum;
  logic [13:0]        score_clamped;

  assign haz_in = step_spike_collision | border_collision;

  // Both awards are summed in 15 bits before the single clamp so a gate+prize frame saturates cleanly.
  assign score_sum = {1'b0, score_q}
                   + (prz_q ? 15'(PRIZE_POINTS) : 15'd0)
                   + (gat_q ? 15'(GATE_POINTS)  : 15'd0);
  assign score_clamped = (score_sum > SCORE_CAP) ? SCORE_CAP[13:0] : score_sum[13:0];

`ifdef BONUS_LIFE_EN
  localparam logic [13:0] BONUS_T = 14'(BONUS_THRESHOLD);

  logic       armed_q, armed_d;
  logic       bonus;
  logic [2:0] lives_inc;

  assign bonus = armed_q && startOfFrame && (state_q == S_PLAY || state_q == S_HIT)
              && (score_q < BONUS_T) && (score_clamped >= BONUS_T);
  assign lives_inc = (lives_q < 3'(MAX_LIVES)) ? lives_q + 3'd1 : lives_q;
`endif

  // NOTE: every variable is given a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_d     = score_q;
    lives_d     = lives_q;
    level_d     = level_q;
    life_lost_d = 1'b0;
    level_up_d  = 1'b0;
`ifdef BONUS_LIFE_EN
    armed_d     = armed_q;
`endif

    // A startOfFrame cycle's own collisions belong to the frame that is just starting.
    if (startOfFrame) begin
      prz_d = prize_collision;
      gat_d = gate_collision;
      haz_d = haz_in;
    end else begin
      prz_d = prz_q | prize_collision;
      gat_d = gat_q | gate_collision;
      haz_d = haz_q | haz_in;
    end

    unique case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start_game) begin
          state_d = S_PLAY;
          score_d = '0;
          lives_d = LIVES_INIT;
          level_d = 4'd1;
          cnt_d   = '0;
          prz_d   = 1'b0;
          gat_d   = 1'b0;
          haz_d   = 1'b0;
`ifdef BONUS_LIFE_EN
          armed_d = 1'b1;
`endif
        end
      end

      S_PLAY, S_HIT: begin
        if (startOfFrame) begin
          score_d = score_clamped;
          if (gat_q) begin
            level_d    = (level_q >= 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : level_q + 4'd1;
            level_up_d = 1'b1;
            cnt_d      = CNT_W'(LEVEL_UP_FRAMES);
            state_d    = S_LEVEL_UP;
          end else if (state_q == S_PLAY && haz_q) begin
            life_lost_d = 1'b1;
            if (lives_q <= 3'd1) begin
              lives_d = '0;
              state_d = S_GAME_OVER;
            end else begin
              lives_d = lives_q - 3'd1;
              cnt_d   = CNT_W'(INVULN_FRAMES);
              state_d = S_HIT;
            end
          end else if (state_q == S_HIT) begin
            if (cnt_q <= CNT_W'(1)) begin
              cnt_d   = '0;
              state_d = S_PLAY;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
      end

      S_LEVEL_UP: begin
        if (startOfFrame) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef BONUS_LIFE_EN
    // A bonus in a hazard frame cancels the deduction, so the player stays alive and enters HIT.
    if (bonus) begin
      armed_d = 1'b0;
      lives_d = life_lost_d ? lives_q : lives_inc;
      if (state_d == S_GAME_OVER) begin
        cnt_d   = CNT_W'(INVULN_FRAMES);
        state_d = S_HIT;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      prz_q       <= 1'b0;
      gat_q       <= 1'b0;
      haz_q       <= 1'b0;
      cnt_q       <= '0;
      score_q     <= '0;
      lives_q     <= LIVES_INIT;
      level_q     <= 4'd1;
      life_lost_q <= 1'b0;
      level_up_q  <= 1'b0;
`ifdef BONUS_LIFE_EN
      armed_q     <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      prz_q       <= prz_d;
      gat_q       <= gat_d;
      haz_q       <= haz_d;
      cnt_q       <= cnt_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      life_lost_q <= life_lost_d;
      level_up_q  <= level_up_d;
`ifdef BONUS_LIFE_EN
      armed_q     <= armed_d;
`endif
    end
  end

  assign score           = score_q;
  assign lives           = lives_q;
  assign level           = level_q;
  assign playing         = (state_q == S_PLAY) || (state_q == S_HIT);
  assign invulnerable    = (state_q == S_HIT);
  assign game_over       = (state_q == S_GAME_OVER);
  assign life_lost_pulse = life_lost_q;
  assign level_up_pulse  = level_up_q;

endmodule
